// File: rtl/mine_placer.sv
// Places n distinct mines on a 5x5 board from a 5-bit LCG; falls back to lowest-free fill after 64 consecutive rejects.
// Latency: request -> INIT -> one GEN or FILL cycle per candidate -> DONE; in_place is ignored while busy.
module mine_placer (
    input  logic        in_clka,
    input  logic        in_restart,
    input  logic        in_place,
    input  logic [4:0]  in_seed,
    input  logic [4:0]  in_mult,
    input  logic [4:0]  in_incr,
    input  logic [4:0]  in_n_mines,
    output logic [24:0] out_mines,
    output logic        out_place_done,
    output logic        out_busy,
    output logic [2:0]  out_state,
    output logic [4:0]  out_placed_cnt,
    output logic [4:0]  out_cand
);
    localparam int N_CELLS   = 25;
    localparam int MAX_MINES = 24;
    localparam int MAX_TRIES = 64;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_GEN  = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state;
    logic [24:0] mines;
    logic [4:0]  cnt;
    logic [4:0]  cand;
    logic [4:0]  mult;
    logic [4:0]  incr;
    logic [4:0]  n_tgt;
    logic [6:0]  stall;

    logic [9:0]  prod;
    logic [4:0]  nxt;
    logic        nxt_ok;
    logic [4:0]  free_idx;
    logic        free_found;
    logic [4:0]  cnt_inc;
    logic [6:0]  stall_inc;
    logic [4:0]  n_clamp;
    logic        start;

    always_comb begin
        prod       = {5'd0, cand} * {5'd0, mult};
        nxt        = prod[4:0] + incr;
        nxt_ok     = 1'b0;
        if (nxt < 5'(N_CELLS))
            nxt_ok = ~mines[nxt];
        cnt_inc    = cnt + 5'd1;
        stall_inc  = stall + 7'd1;
        n_clamp    = (in_n_mines > 5'(MAX_MINES)) ? 5'(MAX_MINES) : in_n_mines;
        start      = in_place && ((state == S_IDLE) || (state == S_DONE));
        // FILL target: lowest-index clear cell
        free_idx   = 5'd0;
        free_found = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (!free_found && !mines[i]) begin
                free_idx   = 5'(i);
                free_found = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state <= S_IDLE;
            mines <= '0;
            cnt   <= '0;
            cand  <= '0;
            mult  <= '0;
            incr  <= '0;
            n_tgt <= '0;
            stall <= '0;
        end else if (start) begin
            mult  <= in_mult;
            incr  <= in_incr;
            n_tgt <= n_clamp;
            cand  <= in_seed;
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT: begin
                    mines <= '0;
                    cnt   <= '0;
                    stall <= '0;
                    state <= (n_tgt == 5'd0) ? S_DONE : S_GEN;
                end
                S_GEN: begin
                    cand <= nxt;
                    if (nxt_ok) begin
                        mines <= mines | (25'd1 << nxt);
                        cnt   <= cnt_inc;
                        stall <= '0;
                        if (cnt_inc == n_tgt)
                            state <= S_DONE;
                    end else begin
                        stall <= stall_inc;
                        if (stall_inc == 7'(MAX_TRIES))
                            state <= S_FILL;
                    end
                end
                S_FILL: begin
                    mines <= mines | (25'd1 << free_idx);
                    cnt   <= cnt_inc;
                    if (cnt_inc == n_tgt)
                        state <= S_DONE;
                end
                S_IDLE, S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_mines      = mines;
    assign out_placed_cnt = cnt;
    assign out_cand       = cand;
    assign out_state      = state;
    assign out_place_done = (state == S_DONE);
    assign out_busy       = (state == S_INIT) || (state == S_GEN) || (state == S_FILL);
endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: each accepted request is expanded into its full per-cycle output trajectory.
module tb_mine_placer;
    logic        clk = 1'b0;
    logic        restart = 1'b0;
    logic        place = 1'b0;
    logic [4:0]  seed = '0, mult = '0, incr = '0, n_mines = '0;
    logic [24:0] out_mines;
    logic        out_place_done, out_busy;
    logic [2:0]  out_state;
    logic [4:0]  out_placed_cnt, out_cand;

    mine_placer dut (
        .in_clka(clk), .in_restart(restart), .in_place(place),
        .in_seed(seed), .in_mult(mult), .in_incr(incr), .in_n_mines(n_mines),
        .out_mines(out_mines), .out_place_done(out_place_done), .out_busy(out_busy),
        .out_state(out_state), .out_placed_cnt(out_placed_cnt), .out_cand(out_cand)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [24:0] mines;
        logic [4:0]  cnt;
        logic [4:0]  cand;
    } snap_t;

    snap_t q[$];
    snap_t exp_s;
    bit    armed = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic snap_t mk(input logic [2:0] st, input logic [24:0] m,
                                 input logic [4:0] c, input logic [4:0] cd);
        snap_t s;
        s.st = st; s.mines = m; s.cnt = c; s.cand = cd;
        return s;
    endfunction

    // Plays the whole placement algorithmically and queues what each following cycle must show.
    task automatic plan(input int s, input int m, input int c, input int req, input snap_t cur);
        int n, cnt, cand, stall, i;
        logic [24:0] b;
        n = (req > 24) ? 24 : req;
        q.push_back(mk(3'd1, cur.mines, cur.cnt, 5'(s)));
        q.push_back(mk((n == 0) ? 3'd4 : 3'd2, '0, 5'd0, 5'(s)));
        b = '0; cnt = 0; cand = s; stall = 0;
        while (cnt < n) begin
            if (stall < 64) begin
                cand = (cand * m + c) % 32;
                if (cand < 25 && !b[cand]) begin
                    b[cand] = 1'b1; cnt++; stall = 0;
                end else begin
                    stall++;
                end
                q.push_back(mk((cnt == n) ? 3'd4 : (stall == 64) ? 3'd3 : 3'd2, b, 5'(cnt), 5'(cand)));
            end else begin
                i = 0;
                while (b[i]) i++;
                b[i] = 1'b1; cnt++;
                q.push_back(mk((cnt == n) ? 3'd4 : 3'd3, b, 5'(cnt), 5'(cand)));
            end
        end
    endtask

    always @(posedge clk) begin
        if (restart) begin
            q.delete();
            exp_s = '0;
            armed = 1'b1;
        end else if (armed) begin
            if (q.size() > 0)
                exp_s = q.pop_front();
            else if ((exp_s.st == 3'd0 || exp_s.st == 3'd4) && place) begin
                plan(seed, mult, incr, n_mines, exp_s);
                exp_s = q.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("state", out_state, exp_s.st);
            chk("mines", out_mines, exp_s.mines);
            chk("placed_cnt", out_placed_cnt, exp_s.cnt);
            chk("cand", out_cand, exp_s.cand);
            chk("busy", out_busy, (exp_s.st >= 3'd1 && exp_s.st <= 3'd3));
            chk("done", out_place_done, (exp_s.st == 3'd4));
        end
    end

    task automatic request(input logic [4:0] s, input logic [4:0] m, input logic [4:0] c, input logic [4:0] n);
        @(negedge clk);
        seed = s; mult = m; incr = c; n_mines = n; place = 1'b1;
        @(negedge clk);
        place = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_place_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_place_done) chk("done_timeout", out_place_done, 1);
    endtask

    initial begin
        int cyc;
        bit abort;
        int at;
        restart = 1'b1;
        repeat (2) @(negedge clk);
        restart = 1'b0;
        chk("rst_state", out_state, 0);
        chk("rst_mines", out_mines, 0);
        chk("rst_busy", out_busy, 0);

        request(5'd0, 5'd5, 5'd3, 5'd4);
        wait_done(cyc);
        chk("norm_latency", cyc, 6);
        chk("norm_mines", out_mines, 32'h0140088);
        chk("norm_cnt", out_placed_cnt, 4);
        chk("norm_cand", out_cand, 7);

        request(5'd7, 5'd5, 5'd3, 5'd4);
        chk("re_init_state", out_state, 1);
        chk("re_init_cand", out_cand, 7);
        @(negedge clk);
        chk("re_cleared", out_mines, 0);
        place = 1'b1; seed = 5'd0; mult = 5'd8; incr = 5'd13; n_mines = 5'd3;
        repeat (2) @(negedge clk);
        place = 1'b0;
        wait_done(cyc);
        chk("re_mines", out_mines, 32'h0000942);
        chk("re_cnt", out_placed_cnt, 4);

        request(5'd5, 5'd5, 5'd3, 5'd0);
        wait_done(cyc);
        chk("zero_latency", cyc, 1);
        chk("zero_mines", out_mines, 0);
        chk("zero_cand", out_cand, 5);

        request(5'd0, 5'd8, 5'd13, 5'd3);
        wait_done(cyc);
        chk("stall_latency", cyc, 68);
        chk("stall_mines", out_mines, 32'h0202001);
        chk("stall_cnt", out_placed_cnt, 3);
        chk("stall_cand", out_cand, 21);

        request(5'd0, 5'd5, 5'd3, 5'd30);
        wait_done(cyc);
        chk("clamp_cnt", out_placed_cnt, 24);
        chk("clamp_pop", $countones(out_mines), 24);
        chk("clamp_mines", out_mines, 32'h1FFFFFE);
        chk("clamp_cand", out_cand, 12);

        request(5'd0, 5'd8, 5'd13, 5'd3);
        repeat (10) @(negedge clk);
        chk("mid_state", out_state, 2);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("mid_rst_state", out_state, 0);
        chk("mid_rst_mines", out_mines, 0);
        chk("mid_rst_cnt", out_placed_cnt, 0);
        chk("mid_rst_cand", out_cand, 0);
        chk("mid_rst_busy", out_busy, 0);
        chk("mid_rst_done", out_place_done, 0);

        for (int t = 0; t < 40; t++) begin
            request(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            abort = ($urandom_range(0, 5) == 0);
            at = $urandom_range(1, 30);
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (out_place_done) break;
                if (abort && c == at) begin
                    restart = 1'b1;
                    @(negedge clk);
                    restart = 1'b0;
                    break;
                end
                place = ($urandom_range(0, 3) == 0);
                seed = 5'($urandom); mult = 5'($urandom);
                incr = 5'($urandom); n_mines = 5'($urandom);
            end
            place = 1'b0;
            if (!abort || !(out_state == 3'd0)) begin
                wait_done(cyc);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mine_placer.md
# mine_placer

Mine-placement stage of the Minesweeper datapath, sitting directly upstream of the game loop: it turns the user-supplied LCG constants into the 25-bit `mines` board that load/decode/ALU/display consume. On `in_place` it runs a 5-bit linear congruential generator and places `in_n_mines` distinct mines on the 5×5 board. If the LCG degenerates, it falls back to a deterministic fill so it always terminates. It then holds the board and raises `out_place_done` until reset or a new placement request.

## Interface
- `N_CELLS`, 25, board cells; indices 0..24.
- `MAX_MINES`, 24, clamp for the requested mine count.
- `MAX_TRIES`, 64, consecutive non-placing GEN cycles before switching to FILL.

- `in_clka`  input  1  single clock; all state updates on the rising edge.
- `in_restart`  input  1  reset, synchronous, active-high; overrides all other inputs.
- `in_place`  input  1  start request, sampled in IDLE and DONE.
- `in_seed`  input  5  initial LCG state, latched on start.
- `in_mult`  input  5  LCG multiplier, latched on start.
- `in_incr`  input  5  LCG increment, latched on start.
- `in_n_mines`  input  5  requested mine count, latched on start and clamped to MAX_MINES.
- `out_mines`  output  25  mine bitvector; bit i is set when cell i holds a mine.
- `out_place_done`  output  1  high in DONE only.
- `out_busy`  output  1  high in INIT, GEN and FILL.
- `out_state`  output  3  IDLE=0, INIT=1, GEN=2, FILL=3, DONE=4.
- `out_placed_cnt`  output  5  mines placed so far.
- `out_cand`  output  5  current LCG state (the last candidate).

## Operation
- **Reset** (`in_restart`=1 at an edge): state=IDLE. Clear `out_mines`, `out_placed_cnt`, `out_cand`, the stall counter and the latched constants. Outputs are 0 the next cycle, including when reset arrives mid-GEN or mid-FILL.
- **IDLE**
  - `in_place`=1: latch mult, incr, n = min(`in_n_mines`, 24); set `out_cand` ← `in_seed`; go to INIT.
  - Otherwise stay in IDLE.
- **INIT**: clear mines, count and stall counter. If n=0, go to DONE; otherwise go to GEN.
- **GEN**, one candidate per cycle:
  - next = (cand·mult + incr) mod 32, i.e. the product is truncated to 5 bits. `out_cand` ← next.
  - Placement: if next < 25 and mines[next]=0, set the bit, increment the count and clear the stall counter.
  - Rejection: otherwise increment the stall counter.
  - If this cycle's placement brings the count to n, go to DONE.
  - Else if the stall counter reaches MAX_TRIES, go to FILL.
- **FILL**, one placement per cycle:
  - Set the lowest-index clear bit of mines and increment the count.
  - When the count reaches n, go to DONE.
- **DONE**
  - Hold mines and count.
  - `in_place`=1 latches new constants/seed and goes to INIT, i.e. a full re-placement.
- `in_place` is ignored in INIT, GEN and FILL.
- Invariant: popcount(`out_mines`) = `out_placed_cnt` ≤ 24, and bits 25..31 of the candidate space are never set.

## Timing
- All outputs are registered.
- `in_place` at edge k gives INIT at k+1; GEN begins at k+2, or DONE at k+2 when n=0.
- The GEN cycle that places the n-th mine has state=DONE and `out_place_done`=1 from the following cycle.
- Best-case latency, request to done: n+2 cycles.
- Worst case: 2 + (n−1) placements + MAX_TRIES per stall episode + FILL cycles. Bounded, since FILL needs at most 24 cycles.
- The transition to FILL happens on the edge where the stall counter would reach MAX_TRIES. FILL places its first mine on the next edge.
- `out_busy` and `out_place_done` are never high together.

## Test plan
- **Normal placement:** restart; mult=5, incr=3, seed=0, n=4, pulse `in_place` → candidates 3, 18, 29 (rejected), 20, 7. Done on the cycle after the 5th GEN; `out_mines`=0x0140088; `out_placed_cnt`=4.
- **Stall then FILL:** mult=8, incr=13, seed=0, n=3 → 13 and 21 placed, then 21 repeats. After 64 stall cycles FILL places cell 0; `out_mines`=0x0202001; done high.
- **Zero mines:** n=0 → INIT then DONE; `out_mines`=0; `out_place_done`=1 two cycles after the request.
- **Clamp:** `in_n_mines`=30 with mult=5, incr=3 → `out_placed_cnt`=24, popcount(`out_mines`)=24, exactly one cell clear, and it terminates.
- **Reset mid-operation:** `in_restart` during GEN → next cycle state=0, mines=0, count=0, cand=0, busy=0, done=0.
- **Re-placement from DONE:** after the normal-placement case, pulse `in_place` with seed=7 → INIT clears the board and a fresh placement starts from cand=7. `in_place` pulses during GEN are ignored (the result is unchanged).
